// File: rtl/mipi_rx_pkt_parser.sv
// DSI receive packet parser: decodes packet headers (ECC correct/detect), forwards long-packet
// payload bytes, checks payload CRC-16 and flags HS bursts that end inside a packet.
module mipi_rx_pkt_parser (
    input  logic        CLKn,
    input  logic        RST,
    input  logic [7:0]  Rx_byte,
    input  logic        Rx_byte_valid,
    input  logic        Rx_hs_active,
    output logic [5:0]  Rx_cmd_data_type,
    output logic [1:0]  Rx_cmd_vc,
    output logic [15:0] Rx_cmd_wc,
    output logic        Rx_cmd_long,
    output logic        Rx_cmd_valid,
    output logic [7:0]  Rx_pay_data,
    output logic        Rx_pay_valid,
    output logic        Rx_pay_last,
    output logic        Rx_ecc_corrected,
    output logic        Rx_ecc_err,
    output logic        Rx_crc_err,
    output logic        Rx_trunc_err
);

    typedef enum logic [2:0] {ST_HDR, ST_PAY, ST_CRC0, ST_CRC1, ST_DROP} state_t;

    // Parity masks P0..P5 of the DSI header ECC over {byte2, byte1, byte0}.
    localparam logic [23:0] ECC_MASK [6] = '{
        24'hF12CB7, 24'hF2555B, 24'h749A6D, 24'hB8E38E, 24'hDF03F0, 24'hEFFC00
    };

    function automatic logic [5:0] ecc6(input logic [23:0] d);
        logic [5:0] p;
        for (int k = 0; k < 6; k++) p[k] = ^(d & ECC_MASK[k]);
        return p;
    endfunction

    // Reflected CCITT step (poly 0x8408), payload byte consumed LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        c = crc ^ {8'h00, b};
        for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
        return c;
    endfunction

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [23:0] hdr_q, hdr_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] crc_q, crc_d;
    logic [7:0]  crc0_q, crc0_d;
    logic [5:0]  dt_q, dt_d;
    logic [1:0]  vc_q, vc_d;
    logic [15:0] wc_q, wc_d;
    logic        long_q, long_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic [7:0]  pay_data_q, pay_data_d;
    logic        pay_valid_q, pay_valid_d;
    logic        pay_last_q, pay_last_d;
    logic        corr_q, corr_d;
    logic        ecc_err_q, ecc_err_d;
    logic        crc_err_q, crc_err_d;
    logic        trunc_q, trunc_d;

    logic [5:0]  syn;
    logic [23:0] hdr_fix;
    logic        ecc_ok, ecc_corr, hdr_long;

    // Syndrome decode against the three captured header bytes plus the ECC byte on the bus.
    always_comb begin
        syn      = ecc6(hdr_q) ^ Rx_byte[5:0];
        hdr_fix  = hdr_q;
        ecc_ok   = 1'b0;
        ecc_corr = 1'b0;
        if (syn == 6'd0) begin
            ecc_ok = 1'b1;
        end else if ((syn & (syn - 6'd1)) == 6'd0) begin
            ecc_ok   = 1'b1;   // single error in the ECC byte itself; data is intact
            ecc_corr = 1'b1;
        end else begin
            for (int i = 0; i < 24; i++) begin
                if (syn == ecc6(24'd1 << i)) begin
                    hdr_fix  = hdr_q ^ (24'd1 << i);
                    ecc_ok   = 1'b1;
                    ecc_corr = 1'b1;
                end
            end
        end
        hdr_long = hdr_fix[3:0] inside {4'h9, 4'hC, 4'hD, 4'hE};
    end

    always_comb begin
        // NOTE: every next-state value defaults to hold (or 0 for pulses) so no latch is inferred.
        state_d     = state_q;
        idx_d       = idx_q;
        hdr_d       = hdr_q;
        cnt_d       = cnt_q;
        crc_d       = crc_q;
        crc0_d      = crc0_q;
        dt_d        = dt_q;
        vc_d        = vc_q;
        wc_d        = wc_q;
        long_d      = long_q;
        pay_data_d  = pay_data_q;
        cmd_valid_d = 1'b0;
        pay_valid_d = 1'b0;
        pay_last_d  = 1'b0;
        corr_d      = 1'b0;
        ecc_err_d   = 1'b0;
        crc_err_d   = 1'b0;
        trunc_d     = 1'b0;

        if (!Rx_hs_active) begin
            state_d = ST_HDR;
            idx_d   = 2'd0;
            trunc_d = !((state_q == ST_HDR && idx_q == 2'd0) || state_q == ST_DROP);
        end else if (Rx_byte_valid) begin
            case (state_q)
                ST_HDR: begin
                    if (idx_q != 2'd3) begin
                        case (idx_q)
                            2'd0:    hdr_d[7:0]   = Rx_byte;
                            2'd1:    hdr_d[15:8]  = Rx_byte;
                            default: hdr_d[23:16] = Rx_byte;
                        endcase
                        idx_d = idx_q + 2'd1;
                    end else begin
                        idx_d = 2'd0;
                        crc_d = 16'hFFFF;
                        if (ecc_ok) begin
                            cmd_valid_d = 1'b1;
                            corr_d      = ecc_corr;
                            dt_d        = hdr_fix[5:0];
                            vc_d        = hdr_fix[7:6];
                            wc_d        = hdr_fix[23:8];
                            long_d      = hdr_long;
                            cnt_d       = hdr_fix[23:8];
                            if (hdr_long) state_d = (hdr_fix[23:8] == 16'd0) ? ST_CRC0 : ST_PAY;
                        end else begin
                            ecc_err_d = 1'b1;
                            state_d   = ST_DROP;
                        end
                    end
                end
                ST_PAY: begin
                    pay_valid_d = 1'b1;
                    pay_data_d  = Rx_byte;
                    crc_d       = crc16_byte(crc_q, Rx_byte);
                    cnt_d       = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) begin
                        pay_last_d = 1'b1;
                        state_d    = ST_CRC0;
                    end
                end
                ST_CRC0: begin
                    crc0_d  = Rx_byte;
                    state_d = ST_CRC1;
                end
                ST_CRC1: begin
                    crc_err_d = ({Rx_byte, crc0_q} != crc_q);
                    state_d   = ST_HDR;
                end
                ST_DROP: ;
                default: state_d = ST_HDR;
            endcase
        end
    end

    always_ff @(posedge CLKn or posedge RST) begin
        if (RST) begin
            state_q     <= ST_HDR;
            idx_q       <= 2'd0;
            hdr_q       <= '0;
            cnt_q       <= '0;
            crc_q       <= 16'hFFFF;
            crc0_q      <= '0;
            dt_q        <= '0;
            vc_q        <= '0;
            wc_q        <= '0;
            long_q      <= 1'b0;
            cmd_valid_q <= 1'b0;
            pay_data_q  <= '0;
            pay_valid_q <= 1'b0;
            pay_last_q  <= 1'b0;
            corr_q      <= 1'b0;
            ecc_err_q   <= 1'b0;
            crc_err_q   <= 1'b0;
            trunc_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            hdr_q       <= hdr_d;
            cnt_q       <= cnt_d;
            crc_q       <= crc_d;
            crc0_q      <= crc0_d;
            dt_q        <= dt_d;
            vc_q        <= vc_d;
            wc_q        <= wc_d;
            long_q      <= long_d;
            cmd_valid_q <= cmd_valid_d;
            pay_data_q  <= pay_data_d;
            pay_valid_q <= pay_valid_d;
            pay_last_q  <= pay_last_d;
            corr_q      <= corr_d;
            ecc_err_q   <= ecc_err_d;
            crc_err_q   <= crc_err_d;
            trunc_q     <= trunc_d;
        end
    end

    assign Rx_cmd_data_type = dt_q;
    assign Rx_cmd_vc        = vc_q;
    assign Rx_cmd_wc        = wc_q;
    assign Rx_cmd_long      = long_q;
    assign Rx_cmd_valid     = cmd_valid_q;
    assign Rx_pay_data      = pay_data_q;
    assign Rx_pay_valid     = pay_valid_q;
    assign Rx_pay_last      = pay_last_q;
    assign Rx_ecc_corrected = corr_q;
    assign Rx_ecc_err       = ecc_err_q;
    assign Rx_crc_err       = crc_err_q;
    assign Rx_trunc_err     = trunc_q;

endmodule

// File: tb/tb_mipi_rx_pkt_parser.sv
// Bench for mipi_rx_pkt_parser: directed and random bursts compared against a packet-level
// reference model that predicts every output event and the clock edge it belongs to.
module tb_mipi_rx_pkt_parser;

    logic        CLKn = 1'b0;
    logic        RST;
    logic [7:0]  Rx_byte;
    logic        Rx_byte_valid;
    logic        Rx_hs_active;
    logic [5:0]  Rx_cmd_data_type;
    logic [1:0]  Rx_cmd_vc;
    logic [15:0] Rx_cmd_wc;
    logic        Rx_cmd_long;
    logic        Rx_cmd_valid;
    logic [7:0]  Rx_pay_data;
    logic        Rx_pay_valid;
    logic        Rx_pay_last;
    logic        Rx_ecc_corrected;
    logic        Rx_ecc_err;
    logic        Rx_crc_err;
    logic        Rx_trunc_err;

    mipi_rx_pkt_parser dut (
        .CLKn(CLKn), .RST(RST), .Rx_byte(Rx_byte), .Rx_byte_valid(Rx_byte_valid),
        .Rx_hs_active(Rx_hs_active), .Rx_cmd_data_type(Rx_cmd_data_type), .Rx_cmd_vc(Rx_cmd_vc),
        .Rx_cmd_wc(Rx_cmd_wc), .Rx_cmd_long(Rx_cmd_long), .Rx_cmd_valid(Rx_cmd_valid),
        .Rx_pay_data(Rx_pay_data), .Rx_pay_valid(Rx_pay_valid), .Rx_pay_last(Rx_pay_last),
        .Rx_ecc_corrected(Rx_ecc_corrected), .Rx_ecc_err(Rx_ecc_err), .Rx_crc_err(Rx_crc_err),
        .Rx_trunc_err(Rx_trunc_err)
    );

    always #5 CLKn = ~CLKn;

    int cyc = 0;
    always @(posedge CLKn) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
        end
    endtask

    localparam logic [3:0] K_CMD = 4'd1, K_PAY = 4'd2, K_ECC = 4'd3, K_CRC = 4'd4,
                           K_TRUNC = 4'd5, K_STRAY = 4'd6;

    typedef struct packed {
        logic [3:0]  kind;
        logic [27:0] at;
        logic [31:0] val;
    } evt_t;

    evt_t       obs_q[$];
    evt_t       exp_q[$];
    logic [7:0] bq[$];
    int         acc[$];
    int         fall_edge;

    function automatic evt_t mk(input logic [3:0] kind, input int at, input logic [31:0] val);
        evt_t ev;
        ev.kind = kind;
        ev.at   = 28'(at);
        ev.val  = val;
        return ev;
    endfunction

    // Each output pulse becomes one event stamped with the edge that registered it.
    always @(negedge CLKn) begin
        if (!RST) begin
            if (Rx_cmd_valid)
                obs_q.push_back(mk(K_CMD, cyc, {6'b0, Rx_ecc_corrected, Rx_cmd_long, Rx_cmd_vc,
                                                Rx_cmd_data_type, Rx_cmd_wc}));
            if (Rx_ecc_corrected && !Rx_cmd_valid) obs_q.push_back(mk(K_STRAY, cyc, 32'd1));
            if (Rx_ecc_err)   obs_q.push_back(mk(K_ECC, cyc, 32'd0));
            if (Rx_pay_valid) obs_q.push_back(mk(K_PAY, cyc, {23'b0, Rx_pay_last, Rx_pay_data}));
            if (Rx_pay_last && !Rx_pay_valid) obs_q.push_back(mk(K_STRAY, cyc, 32'd2));
            if (Rx_crc_err)   obs_q.push_back(mk(K_CRC, cyc, 32'd0));
            if (Rx_trunc_err) obs_q.push_back(mk(K_TRUNC, cyc, 32'd0));
        end
    end

    // ---------------- reference model ----------------
    // ECC contribution of each header data bit, as {P5..P0}.
    localparam logic [5:0] COL [24] = '{
        6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19, 6'h1A, 6'h1C, 6'h23, 6'h25,
        6'h26, 6'h29, 6'h2A, 6'h2C, 6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B
    };

    function automatic logic [5:0] ecc_of(input logic [23:0] d);
        logic [5:0] e;
        e = 6'd0;
        for (int i = 0; i < 24; i++) if (d[i]) e ^= COL[i];
        return e;
    endfunction

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] b);
        logic fb;
        for (int i = 0; i < 8; i++) begin
            fb = c[0] ^ b[i];
            c  = c >> 1;
            if (fb) c ^= 16'h8408;
        end
        return c;
    endfunction

    function automatic bit is_long(input logic [5:0] dt);
        return dt[3:0] inside {4'h9, 4'hC, 4'hD, 4'hE};
    endfunction

    task automatic build_expected();
        int          i;
        int          n;
        int          wc;
        logic [23:0] h;
        logic [5:0]  syn;
        logic [15:0] crc;
        bit          ok;
        bit          corr;
        i = 0;
        n = bq.size();
        exp_q.delete();
        while (i < n) begin
            if (i + 4 > n) begin exp_q.push_back(mk(K_TRUNC, fall_edge, 32'd0)); return; end
            h    = {bq[i+2], bq[i+1], bq[i]};
            syn  = ecc_of(h) ^ bq[i+3][5:0];
            ok   = (syn == 6'd0);
            corr = 1'b0;
            for (int j = 0; j < 24; j++) begin
                if (!ok && ecc_of(h ^ (24'd1 << j)) == bq[i+3][5:0]) begin
                    h    = h ^ (24'd1 << j);
                    ok   = 1'b1;
                    corr = 1'b1;
                end
            end
            if (!ok && $countones(syn) == 1) begin ok = 1'b1; corr = 1'b1; end
            if (!ok) begin exp_q.push_back(mk(K_ECC, acc[i+3], 32'd0)); return; end
            exp_q.push_back(mk(K_CMD, acc[i+3],
                               {6'b0, corr, is_long(h[5:0]), h[7:6], h[5:0], h[23:8]}));
            i += 4;
            if (is_long(h[5:0])) begin
                wc  = int'(h[23:8]);
                crc = 16'hFFFF;
                for (int k = 0; k < wc; k++) begin
                    if (i >= n) begin exp_q.push_back(mk(K_TRUNC, fall_edge, 32'd0)); return; end
                    exp_q.push_back(mk(K_PAY, acc[i], {23'b0, (k == wc - 1) ? 1'b1 : 1'b0, bq[i]}));
                    crc = crc_step(crc, bq[i]);
                    i++;
                end
                if (i + 2 > n) begin exp_q.push_back(mk(K_TRUNC, fall_edge, 32'd0)); return; end
                if ({bq[i+1], bq[i]} != crc) exp_q.push_back(mk(K_CRC, acc[i+1], 32'd0));
                i += 2;
            end
        end
    endtask

    // Appends one packet; flip bits 0..23 corrupt the header data, 24..29 the ECC byte.
    task automatic add_pkt(input logic [7:0] di, input logic [15:0] wc, input logic [29:0] flip,
                           input logic [15:0] crc_xor, input bit rnd_pay);
        logic [23:0] h;
        logic [7:0]  e;
        logic [7:0]  p;
        logic [15:0] crc;
        h = {wc, di};
        e = {2'b00, ecc_of(h)};
        h = h ^ flip[23:0];
        e[5:0] = e[5:0] ^ flip[29:24];
        bq.push_back(h[7:0]);
        bq.push_back(h[15:8]);
        bq.push_back(h[23:16]);
        bq.push_back(e);
        if (is_long(di[5:0])) begin
            crc = 16'hFFFF;
            for (int k = 0; k < int'(wc); k++) begin
                p = rnd_pay ? 8'($urandom) : 8'(16 + k);
                bq.push_back(p);
                crc = crc_step(crc, p);
            end
            crc = crc ^ crc_xor;
            bq.push_back(crc[7:0]);
            bq.push_back(crc[15:8]);
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic drive(input logic v, input logic [7:0] d, input logic hs, output int e);
        @(posedge CLKn);
        #1;
        Rx_byte_valid = v;
        Rx_byte       = d;
        Rx_hs_active  = hs;
        e = cyc + 1;
    endtask

    task automatic run_burst(input string tag, input int gap_pct);
        int e;
        obs_q.delete();
        acc.delete();
        drive(1'b0, 8'h00, 1'b1, e);
        foreach (bq[k]) begin
            while ($urandom_range(99) < gap_pct) drive(1'b0, 8'($urandom), 1'b1, e);
            drive(1'b1, bq[k], 1'b1, e);
            acc.push_back(e);
        end
        // A byte presented as the burst ends must be ignored.
        drive(1'($urandom_range(1)), 8'($urandom), 1'b0, e);
        fall_edge = e;
        for (int k = 0; k < 4; k++) drive(1'($urandom_range(1)), 8'($urandom), 1'b0, e);
        @(negedge CLKn);
        build_expected();
        check({tag, " events"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) check(tag, obs_q[k], exp_q[k]);
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({Rx_cmd_data_type, Rx_cmd_vc, Rx_cmd_wc, Rx_cmd_long, Rx_cmd_valid, Rx_pay_data,
                    Rx_pay_valid, Rx_pay_last, Rx_ecc_corrected, Rx_ecc_err, Rx_crc_err,
                    Rx_trunc_err});
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          e;
        int          np;
        int          b1;
        int          cut;
        logic [7:0]  di;
        logic [15:0] wc;
        logic [29:0] flip;
        logic [15:0] cx;
        logic [5:0]  dts [8] = '{6'h01, 6'h21, 6'h08, 6'h3E, 6'h29, 6'h2C, 6'h1D, 6'h19};

        RST = 1'b1; Rx_byte = 8'h00; Rx_byte_valid = 1'b0; Rx_hs_active = 1'b0;
        repeat (3) @(posedge CLKn);
        #1;
        check("reset outputs", all_outs(), 64'd0);
        @(negedge CLKn);
        RST = 1'b0;

        bq = '{8'h21, 8'h00, 8'h00, 8'h12};
        run_burst("short clean", 0);
        check("clean dt", 64'(Rx_cmd_data_type), 64'h21);
        check("clean wc", 64'(Rx_cmd_wc), 64'h0000);

        bq = '{8'h21, 8'h01, 8'h00, 8'h12};
        run_burst("short corrected", 0);
        check("corrected wc", 64'(Rx_cmd_wc), 64'h0000);

        bq = '{8'h01, 8'h00, 8'h00, 8'h07, 8'h21, 8'h00, 8'h00, 8'h12, 8'h08, 8'h0F, 8'h0F, 8'h01};
        run_burst("three shorts", 40);
        check("three dt", 64'(Rx_cmd_data_type), 64'h08);
        check("three wc", 64'(Rx_cmd_wc), 64'h0F0F);

        bq.delete(); add_pkt(8'h3E, 16'd6, 30'd0, 16'h0000, 1'b0);
        run_burst("long ok", 0);
        check("long flag", 64'(Rx_cmd_long), 64'd1);
        check("last payload", 64'(Rx_pay_data), 64'h15);

        bq.delete(); add_pkt(8'h3E, 16'd6, 30'd0, 16'h0001, 1'b0);
        run_burst("long bad crc", 20);

        bq.delete(); add_pkt(8'h3E, 16'd6, 30'd0, 16'h0000, 1'b0);
        while (bq.size() > 7) void'(bq.pop_back());
        run_burst("long truncated", 0);
        bq = '{8'h21, 8'h00, 8'h00, 8'h12};
        run_burst("after trunc", 0);

        bq = '{8'h21, 8'h03, 8'h00, 8'h12, 8'h01, 8'h00, 8'h00, 8'h07, 8'h55};
        run_burst("ecc drop", 10);

        bq.delete(); add_pkt(8'h3E, 16'd6, 30'd0, 16'h0000, 1'b0);
        drive(1'b0, 8'h00, 1'b1, e);
        for (int k = 0; k < 7; k++) drive(1'b1, bq[k], 1'b1, e);
        drive(1'b0, 8'h00, 1'b1, e);
        check("pre reset pay", 64'({Rx_pay_valid, Rx_pay_data}), 64'h112);
        RST = 1'b1;
        Rx_hs_active = 1'b0;
        #1;
        check("mid reset outputs", all_outs(), 64'd0);
        repeat (2) drive(1'b0, 8'h00, 1'b0, e);
        RST = 1'b0;
        bq = '{8'h21, 8'h00, 8'h00, 8'h12};
        run_burst("after reset", 0);

        for (int t = 0; t < 30; t++) begin
            bq.delete();
            np = $urandom_range(1, 3);
            for (int p = 0; p < np; p++) begin
                di = {2'($urandom), ($urandom_range(3) == 0) ? 6'($urandom) : dts[$urandom_range(7)]};
                wc = is_long(di[5:0]) ? 16'($urandom_range(8)) : 16'($urandom);
                flip = 30'd0;
                case ($urandom_range(9))
                    0: flip[$urandom_range(29)] = 1'b1;
                    1: begin
                        b1 = $urandom_range(29);
                        flip[b1] = 1'b1;
                        flip[(b1 + $urandom_range(1, 29)) % 30] = 1'b1;
                    end
                    default: ;
                endcase
                cx = ($urandom_range(5) == 0) ? 16'($urandom_range(1, 65535)) : 16'h0000;
                add_pkt(di, wc, flip, cx, 1'b1);
            end
            if ($urandom_range(3) == 0) begin
                cut = $urandom_range(1, bq.size() - 1);
                while (bq.size() > cut) void'(bq.pop_back());
            end
            run_burst("random", $urandom_range(50));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
